// File: rtl/gor16_acc.sv
// Streaming OR-reduction stage: folds a packet of 16-bit words through gor16
// and presents the packet-wide OR plus word count on a valid/ready output.

module gor16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   assign y = a | b;

endmodule

module gor16_acc #(
   parameter int MAX_WORDS = 16,
   parameter int CW        = $clog2(MAX_WORDS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   out_data,
   output logic [CW-1:0] out_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   out_data_q, out_data_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic [15:0]   acc_y;
   logic [CW:0]   cnt_inc;
   logic          accept;
   logic          deliver;
   logic          is_end;

   gor16 u_gor16 (
      .a (acc_q),
      .b (in_data),
      .y (acc_y)
   );

   assign accept  = in_valid && in_ready_q;
   assign deliver = out_valid_q && out_ready;
   assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
   // Reaching MAX_WORDS closes the packet even without in_last.
   assign is_end  = in_last || (cnt_inc == (CW+1)'(MAX_WORDS));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE, ACC: begin
            if (accept) begin
               acc_d = acc_y;
               cnt_d = cnt_inc[CW-1:0];
               if (is_end) begin
                  state_d     = DONE;
                  out_data_d  = acc_y;
                  out_count_d = cnt_inc[CW-1:0];
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = ACC;
               end
            end
         end
         DONE: begin
            if (deliver) begin
               state_d     = IDLE;
               acc_d       = '0;
               cnt_d       = '0;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_count_q <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_gor16_acc.sv
// Directed bench for gor16_acc: hand-computed packet ORs and counts,
// backpressure, input gaps, forced end at MAX_WORDS and async reset.

module tb_gor16_acc;

   localparam int MW = 16;
   localparam int CW = $clog2(MW + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_data;
   logic [CW-1:0] out_count;

   int n_chk  = 0;
   int n_pass = 0;

   gor16_acc #(.MAX_WORDS(MW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic push(input logic [15:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_result(input string tag, input logic [15:0] d,
                                input int c);
      chk({tag, "_ov"}, 32'(out_valid), 32'd1);
      chk({tag, "_ir"}, 32'(in_ready), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'(d));
      chk({tag, "_cnt"}, 32'(out_count), 32'(c));
   endtask

   task automatic deliver(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_dlv_ir"}, 32'(in_ready), 32'd1);
      chk({tag, "_dlv_ov"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      idle(2);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_ir", 32'(in_ready), 32'd1);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_cnt", 32'(out_count), 32'd0);
      idle(2);
      rst = 1'b0;
      idle(1);

      push(16'h0001, 1'b0);
      push(16'h0010, 1'b0);
      push(16'h8000, 1'b1);
      expect_result("p3", 16'h8011, 3);
      deliver("p3");

      push(16'hA5A5, 1'b1);
      expect_result("p1", 16'hA5A5, 1);
      deliver("p1");

      push(16'h00F0, 1'b0);
      push(16'h0F00, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         expect_result("bp", 16'h0FF0, 2);
         idle(1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      deliver("bp");

      push(16'h0003, 1'b0);
      idle(2);
      push(16'h0300, 1'b0);
      idle(1);
      push(16'h3000, 1'b1);
      expect_result("gap", 16'h3303, 3);
      deliver("gap");

      for (int i = 0; i < MW; i++) begin
         chk("fe_ir", 32'(in_ready), 32'd1);
         push(16'(1 << i), 1'b0);
      end
      expect_result("fe", 16'hFFFF, MW);
      deliver("fe");

      push(16'h0042, 1'b0);
      chk("nx_ir", 32'(in_ready), 32'd1);
      chk("nx_ov", 32'(out_valid), 32'd0);
      push(16'h0001, 1'b1);
      expect_result("nx", 16'h0043, 2);
      deliver("nx");

      push(16'h000F, 1'b0);
      push(16'h00F0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_ir", 32'(in_ready), 32'd1);
      chk("mrst_cnt", 32'(out_count), 32'd0);
      idle(1);
      rst = 1'b0;
      push(16'h0100, 1'b1);
      expect_result("mrst", 16'h0100, 1);
      deliver("mrst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
